// File: rtl/ntt_bram_pkg.sv
// rtl/ntt_bram_pkg.sv - shared types and geometry helpers for the NTT coefficient bank array
package ntt_bram_pkg;

    typedef enum logic [1:0] {
        MODE_NONE    = 2'b00,
        MODE_LOAD    = 2'b01,
        MODE_COMPUTE = 2'b10,
        MODE_DUMP    = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_COMPUTE,
        ST_DUMP
    } state_e;

    localparam int NUM_BU_DEF     = 8;
    localparam int ADDR_WIDTH_DEF = 5;
    localparam int NB             = 2 * NUM_BU_DEF;
    localparam int DEPTH          = 2 ** ADDR_WIDTH_DEF;

    function automatic int num_banks(input int num_bu);
        return 2 * num_bu;
    endfunction

    function automatic int page_depth(input int addr_width);
        return 1 << addr_width;
    endfunction

endpackage

// File: rtl/ntt_bram_bank.sv
// rtl/ntt_bram_bank.sv - one simple dual-port coefficient bank holding two pages, registered read
module ntt_bram_bank #(
    parameter int DATA_WIDTH = 12,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH:0]   wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH:0]   rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    // Address MSB selects the page, so both pages live in one array
    logic [DATA_WIDTH-1:0] mem [0:(2**(ADDR_WIDTH+1))-1];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/ntt_bank_array.sv
// rtl/ntt_bank_array.sv - double-buffered NTT coefficient memory with load, compute and dump modes
module ntt_bank_array
    import ntt_bram_pkg::*;
#(
    parameter int DATA_WIDTH = 12,
    parameter int NUM_BU     = 8,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_STAGES = 7
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic [1:0]                          mode_i,
    input  logic                                start_i,
    input  logic                                load_valid_i,
    input  logic [DATA_WIDTH-1:0]               load_data_i,
    output logic                                load_ready_o,
    input  logic [2*NUM_BU-1:0]                 rd_en_i,
    input  logic [2*NUM_BU*ADDR_WIDTH-1:0]      rd_addr_i,
    output logic [2*NUM_BU*DATA_WIDTH-1:0]      rd_data_o,
    output logic [2*NUM_BU-1:0]                 rd_valid_o,
    input  logic [2*NUM_BU-1:0]                 wr_en_i,
    input  logic [2*NUM_BU*ADDR_WIDTH-1:0]      wr_addr_i,
    input  logic [2*NUM_BU*DATA_WIDTH-1:0]      wr_data_i,
    input  logic                                stage_done_i,
    output logic [DATA_WIDTH-1:0]               dump_data_o,
    output logic                                dump_valid_o,
    input  logic                                dump_ready_i,
    output logic                                busy_o,
    output logic                                done_o,
    output logic                                page_o
);

    localparam int LANES = num_banks(NUM_BU);
    localparam int TOTAL = LANES * page_depth(ADDR_WIDTH);
    localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int CW    = $clog2(TOTAL);
    localparam int SW    = $clog2(NUM_STAGES + 1);

    localparam logic [LW-1:0]         LANE_LAST  = LW'(LANES - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST  = '1;
    localparam logic [CW-1:0]         CNT_LAST   = CW'(TOTAL - 1);
    localparam logic [SW-1:0]         STAGE_LAST = SW'(NUM_STAGES - 1);

    state_e state, state_nxt;

    logic                  page;
    logic [LW-1:0]         ld_lane;
    logic [ADDR_WIDTH-1:0] ld_addr;
    logic [SW-1:0]         stage_cnt;
    logic [LW-1:0]         is_lane;
    logic [ADDR_WIDTH-1:0] is_addr;
    logic                  issue_all;
    logic                  in_flight;
    logic [LW-1:0]         fl_lane;
    logic [DATA_WIDTH-1:0] obuf [2];
    logic                  wr_ptr, rd_ptr;
    logic [1:0]            occ;
    logic [CW-1:0]         acc_cnt;

    logic load_fire, load_last, stage_fire, stage_last, pop, dump_last, issue;

    assign load_fire  = (state == ST_LOAD) && load_valid_i;
    assign load_last  = load_fire && (ld_lane == LANE_LAST) && (ld_addr == ADDR_LAST);
    assign stage_fire = (state == ST_COMPUTE) && stage_done_i;
    assign stage_last = stage_fire && (stage_cnt == STAGE_LAST);
    assign pop        = dump_valid_o && dump_ready_i;
    assign dump_last  = (state == ST_DUMP) && pop && (acc_cnt == CNT_LAST);
    // Buffer slots already claimed by queued or in-flight words gate new reads
    assign issue      = (state == ST_DUMP) && !issue_all && ((occ + {1'b0, in_flight}) < 2'd2);

    assign page_o       = page;
    assign dump_valid_o = (occ != 2'd0);
    assign dump_data_o  = obuf[rd_ptr];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (start_i) begin
                    case (mode_e'(mode_i))
                        MODE_LOAD:    state_nxt = ST_LOAD;
                        MODE_COMPUTE: state_nxt = ST_COMPUTE;
                        MODE_DUMP:    state_nxt = ST_DUMP;
                        default:      state_nxt = ST_IDLE;
                    endcase
                end
            end
            ST_LOAD:    if (load_last)  state_nxt = ST_IDLE;
            ST_COMPUTE: if (stage_last) state_nxt = ST_IDLE;
            ST_DUMP:    if (dump_last)  state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        load_ready_o = (state == ST_LOAD);
        busy_o       = (state != ST_IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            page       <= 1'b0;
            done_o     <= 1'b0;
            rd_valid_o <= '0;
            ld_lane    <= '0;
            ld_addr    <= '0;
            stage_cnt  <= '0;
            is_lane    <= '0;
            is_addr    <= '0;
            issue_all  <= 1'b0;
            in_flight  <= 1'b0;
            fl_lane    <= '0;
            obuf[0]    <= '0;
            obuf[1]    <= '0;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            occ        <= '0;
            acc_cnt    <= '0;
        end else begin
            done_o     <= load_last || stage_last || dump_last;
            rd_valid_o <= (state == ST_COMPUTE) ? rd_en_i : '0;
            if (stage_fire) begin
                page <= ~page;
            end
            if (state == ST_IDLE) begin
                ld_lane   <= '0;
                ld_addr   <= '0;
                stage_cnt <= '0;
                is_lane   <= '0;
                is_addr   <= '0;
                issue_all <= 1'b0;
                in_flight <= 1'b0;
                wr_ptr    <= 1'b0;
                rd_ptr    <= 1'b0;
                occ       <= '0;
                acc_cnt   <= '0;
            end else begin
                if (load_fire) begin
                    ld_lane <= (ld_lane == LANE_LAST) ? '0 : ld_lane + 1'b1;
                    if (ld_lane == LANE_LAST) begin
                        ld_addr <= ld_addr + 1'b1;
                    end
                end
                if (stage_fire) begin
                    stage_cnt <= stage_last ? '0 : stage_cnt + 1'b1;
                end
                if (issue) begin
                    is_lane <= (is_lane == LANE_LAST) ? '0 : is_lane + 1'b1;
                    if (is_lane == LANE_LAST) begin
                        is_addr <= is_addr + 1'b1;
                        if (is_addr == ADDR_LAST) begin
                            issue_all <= 1'b1;
                        end
                    end
                end
                in_flight <= issue;
                fl_lane   <= is_lane;
                if (in_flight) begin
                    obuf[wr_ptr] <= rd_data_o[fl_lane*DATA_WIDTH +: DATA_WIDTH];
                    wr_ptr       <= ~wr_ptr;
                end
                if (pop) begin
                    rd_ptr  <= ~rd_ptr;
                    acc_cnt <= acc_cnt + 1'b1;
                end
                occ <= occ + {1'b0, in_flight} - {1'b0, pop};
            end
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic                  b_we, b_re;
        logic [ADDR_WIDTH:0]   b_wa, b_ra;
        logic [DATA_WIDTH-1:0] b_wd;

        // Compute traffic reads the current page and writes the other one
        always_comb begin
            b_we = 1'b0;
            b_wa = {page, ld_addr};
            b_wd = load_data_i;
            b_re = 1'b0;
            b_ra = {page, rd_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH]};
            if (state == ST_LOAD) begin
                b_we = load_valid_i && (ld_lane == LW'(i));
            end else if (state == ST_COMPUTE) begin
                b_we = wr_en_i[i];
                b_wa = {~page, wr_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH]};
                b_wd = wr_data_i[i*DATA_WIDTH +: DATA_WIDTH];
                b_re = rd_en_i[i];
            end else if (state == ST_DUMP) begin
                b_re = issue && (is_lane == LW'(i));
                b_ra = {page, is_addr};
            end
        end

        ntt_bram_bank #(
            .DATA_WIDTH(DATA_WIDTH),
            .ADDR_WIDTH(ADDR_WIDTH)
        ) u_bank (
            .clk     (clk_i),
            .rst     (rst_i),
            .wr_en   (b_we),
            .wr_addr (b_wa),
            .wr_data (b_wd),
            .rd_en   (b_re),
            .rd_addr (b_ra),
            .rd_data (rd_data_o[i*DATA_WIDTH +: DATA_WIDTH])
        );
    end

endmodule

// File: tb/tb_ntt_bank_array.sv
// tb/tb_ntt_bank_array.sv - self-checking bench for ntt_bank_array against a coefficient-array model
module tb_ntt_bank_array;

    localparam int DW    = 12;
    localparam int AW    = 5;
    localparam int NB    = 16;
    localparam int DEPTH = 32;
    localparam int TOTAL = NB * DEPTH;

    logic               clk = 1'b0;
    logic               rst;
    logic [1:0]         mode;
    logic               start;
    logic               load_valid;
    logic [DW-1:0]      load_data;
    logic               load_ready;
    logic [NB-1:0]      rd_en;
    logic [NB*AW-1:0]   rd_addr;
    logic [NB*DW-1:0]   rd_data;
    logic [NB-1:0]      rd_valid;
    logic [NB-1:0]      wr_en;
    logic [NB*AW-1:0]   wr_addr;
    logic [NB*DW-1:0]   wr_data;
    logic               stage_done;
    logic [DW-1:0]      dump_data;
    logic               dump_valid;
    logic               dump_ready;
    logic               busy;
    logic               done;
    logic               page;

    int checks = 0;
    int errors = 0;

    // Model: model[p][k] is coefficient index k on page p
    logic [DW-1:0] model [2][TOTAL];
    int            mpage = 0;

    ntt_bank_array #(
        .DATA_WIDTH(DW), .NUM_BU(NB/2), .ADDR_WIDTH(AW), .NUM_STAGES(7)
    ) dut (
        .clk_i(clk), .rst_i(rst), .mode_i(mode), .start_i(start),
        .load_valid_i(load_valid), .load_data_i(load_data), .load_ready_o(load_ready),
        .rd_en_i(rd_en), .rd_addr_i(rd_addr), .rd_data_o(rd_data), .rd_valid_o(rd_valid),
        .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
        .stage_done_i(stage_done), .dump_data_o(dump_data), .dump_valid_o(dump_valid),
        .dump_ready_i(dump_ready), .busy_o(busy), .done_o(done), .page_o(page)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_start(input logic [1:0] m);
        mode = m;
        start = 1'b1;
        tick();
        start = 1'b0;
        mode = 2'b00;
    endtask

    task automatic do_load(input int nwords, input bit seq);
        logic [DW-1:0] v;
        do_start(2'b01);
        chk("load_ready_on", {31'd0, load_ready}, 1);
        chk("load_busy", {31'd0, busy}, 1);
        for (int k = 0; k < nwords; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                load_valid = 1'b0;
                tick();
            end
            v = seq ? DW'(k) : DW'($urandom_range(0, 4095));
            model[mpage][k] = v;
            load_valid = 1'b1;
            load_data = v;
            tick();
            load_valid = 1'b0;
            if (k == TOTAL - 1) begin
                chk("load_done", {31'd0, done}, 1);
                chk("load_idle", {31'd0, busy}, 0);
                tick();
                chk("load_done_once", {31'd0, done}, 0);
            end
        end
    endtask

    task automatic do_dump(input int pattern);
        int idx = 0, cyc = 0, stall = 0, early = 0;
        logic r;
        logic hold = 1'b0;
        logic [DW-1:0] held;
        do_start(2'b11);
        while (idx < TOTAL && cyc < 8000) begin
            if (pattern == 0) r = 1'b1;
            else if (pattern == 1) begin
                if (idx >= 40 && stall < 5) begin r = 1'b0; stall++; end
                else if (idx >= 40) r = cyc[0];
                else r = 1'b1;
            end else r = 1'($urandom_range(0, 1));
            dump_ready = r;
            if (hold) begin
                chk("dump_hold_valid", {31'd0, dump_valid}, 1);
                chk("dump_hold_data", {20'd0, dump_data}, {20'd0, held});
            end
            hold = dump_valid && !r;
            held = dump_data;
            if (dump_valid && r) begin
                chk("dump_data", {20'd0, dump_data}, {20'd0, model[mpage][idx]});
                idx++;
            end
            tick();
            cyc++;
            if (idx < TOTAL && done) early++;
        end
        chk("dump_count", idx, TOTAL);
        chk("dump_no_early_done", early, 0);
        chk("dump_done", {31'd0, done}, 1);
        chk("dump_idle", {31'd0, busy}, 0);
        dump_ready = 1'b0;
        tick();
        chk("dump_done_once", {31'd0, done}, 0);
        chk("dump_valid_off", {31'd0, dump_valid}, 0);
    endtask

    task automatic rand_traffic(input int ncyc);
        logic [NB-1:0] ren, wen;
        logic [DW-1:0] exp_d [NB];
        int a;
        for (int c = 0; c < ncyc; c++) begin
            ren = NB'($urandom);
            wen = NB'($urandom);
            for (int l = 0; l < NB; l++) begin
                a = $urandom_range(0, DEPTH - 1);
                rd_addr[l*AW +: AW] = AW'(a);
                exp_d[l] = model[mpage][a*NB + l];
                a = $urandom_range(0, DEPTH - 1);
                wr_addr[l*AW +: AW] = AW'(a);
                wr_data[l*DW +: DW] = DW'($urandom_range(0, 4095));
                if (wen[l]) model[1-mpage][a*NB + l] = wr_data[l*DW +: DW];
            end
            rd_en = ren;
            wr_en = wen;
            tick();
            rd_en = '0;
            wr_en = '0;
            chk("rand_rd_valid", {16'd0, rd_valid}, {16'd0, ren});
            for (int l = 0; l < NB; l++) begin
                if (ren[l]) chk("rand_rd_data", {20'd0, rd_data[l*DW +: DW]}, {20'd0, exp_d[l]});
            end
        end
    endtask

    initial begin
        rst = 1'b1; mode = '0; start = 1'b0; load_valid = 1'b0; load_data = '0;
        rd_en = '0; rd_addr = '0; wr_en = '0; wr_addr = '0; wr_data = '0;
        stage_done = 1'b0; dump_ready = 1'b0;
        tick();
        tick();
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_page", {31'd0, page}, 0);
        chk("rst_load_ready", {31'd0, load_ready}, 0);
        chk("rst_dump_valid", {31'd0, dump_valid}, 0);
        chk("rst_dump_data", {20'd0, dump_data}, 0);
        chk("rst_rd_valid", {16'd0, rd_valid}, 0);
        chk("rst_rd_data_zero", {31'd0, (rd_data == '0)}, 1);
        rst = 1'b0;
        tick();

        do_load(TOTAL, 1'b1);
        do_dump(0);

        do_start(2'b10);
        chk("cmp_busy", {31'd0, busy}, 1);
        rd_en = 16'h0008;
        rd_addr[3*AW +: AW] = 5'd5;
        tick();
        rd_en = '0;
        chk("lane3_valid", {16'd0, rd_valid}, 32'h0008);
        chk("lane3_data", {20'd0, rd_data[3*DW +: DW]}, {20'd0, model[mpage][5*NB+3]});
        chk("lane3_data_83", {20'd0, rd_data[3*DW +: DW]}, 83);

        rd_addr = '0; wr_addr = '0; wr_data = '0;
        rd_en = 16'h0001; wr_en = 16'h0001; wr_data[DW-1:0] = 12'hABC;
        model[1-mpage][0] = 12'hABC;
        tick();
        rd_en = '0; wr_en = '0;
        chk("rw_same_old", {20'd0, rd_data[DW-1:0]}, {20'd0, model[mpage][0]});
        stage_done = 1'b1;
        tick();
        stage_done = 1'b0;
        mpage ^= 1;
        chk("swap_page", {31'd0, page}, 1);
        rd_en = 16'h0001;
        tick();
        rd_en = '0;
        chk("rw_swapped", {20'd0, rd_data[DW-1:0]}, 32'hABC);

        wr_en = 16'h0002; wr_addr[AW +: AW] = 5'd2; wr_data[DW +: DW] = 12'h5A5;
        model[1-mpage][2*NB+1] = 12'h5A5;
        stage_done = 1'b1;
        tick();
        stage_done = 1'b0; wr_en = '0;
        mpage ^= 1;
        rd_en = 16'h0002; rd_addr[AW +: AW] = 5'd2;
        tick();
        rd_en = '0;
        chk("wr_at_swap", {20'd0, rd_data[DW +: DW]}, 32'h5A5);

        do_start(2'b11);
        chk("start_ignored_busy", {31'd0, busy}, 1);
        chk("start_ignored_dump", {31'd0, dump_valid}, 0);

        for (int s = 2; s < 7; s++) begin
            rand_traffic(6);
            stage_done = 1'b1;
            tick();
            stage_done = 1'b0;
            mpage ^= 1;
            chk("stage_page", {31'd0, page}, mpage);
            chk("stage_done", {31'd0, done}, (s == 6) ? 1 : 0);
            chk("stage_busy", {31'd0, busy}, (s == 6) ? 0 : 1);
        end
        chk("page_after7", {31'd0, page}, 1);
        tick();
        chk("stage_done_once", {31'd0, done}, 0);

        do_load(100, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        mpage = 0;
        chk("abort_busy", {31'd0, busy}, 0);
        chk("abort_load_ready", {31'd0, load_ready}, 0);
        chk("abort_done", {31'd0, done}, 0);
        chk("abort_page", {31'd0, page}, 0);
        tick();
        chk("abort_no_done", {31'd0, done}, 0);
        do_load(TOTAL, 1'b0);
        do_dump(1);

        do_start(2'b00);
        chk("mode0_idle", {31'd0, busy}, 0);
        rd_en = '1; wr_en = '1; wr_data = '1; stage_done = 1'b1;
        tick();
        rd_en = '0; wr_en = '0; stage_done = 1'b0;
        chk("idle_rd_ignored", {16'd0, rd_valid}, 0);
        chk("idle_page_kept", {31'd0, page}, mpage);
        do_dump(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
